// File: rtl/bcd2bin_arbiter.sv
// bcd2bin_arbiter: two requesters share one digit-serial BCD-to-binary engine.
// A round-robin arbiter admits one operand at a time. The engine then folds one
// BCD digit per clock into a binary accumulator, most-significant digit first.
// The result is held on a valid/ready response channel until the consumer takes it.
module bcd2bin_arbiter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [4*N-1:0] req0_bcd,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [4*N-1:0] req1_bcd,
    output logic           req1_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [4*N-1:0] rsp_bin,
    output logic           rsp_id,
    output logic           rsp_err
);

    localparam int W  = 4 * N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_prio;
    logic           r_id;
    logic           r_err;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_opnd;
    logic [CW-1:0]  r_cnt;

    logic           w_grant0;
    logic           w_grant1;
    logic           w_accept;
    logic           w_rsp_hs;
    logic [3:0]     w_digit;
    logic [W-1:0]   w_acc_nxt;

    // A nibble above 9 is not a decimal digit; it is still folded, only flagged.
    function automatic logic nibble_invalid(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Round-robin grant; readys are only offered while the engine is idle.
    always_comb begin
        w_grant0 = req0_valid && (!req1_valid || (r_prio == 1'b0));
        w_grant1 = req1_valid && (!req0_valid || (r_prio == 1'b1));
        if (r_state == ST_IDLE) begin
            req0_ready = w_grant0;
            req1_ready = w_grant1;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        w_accept = req0_ready || req1_ready;
        w_rsp_hs = (r_state == ST_DONE) && rsp_ready;
    end

    // Current digit and the next accumulator value (acc*10 + digit, never overflows).
    always_comb begin
        w_digit   = r_opnd[{r_cnt, 2'b00} +: 4];
        w_acc_nxt = (r_acc * W'(10)) + W'(w_digit);
    end

    // Next-state logic for the IDLE -> CONV -> DONE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CONV;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (r_cnt == CW'(0)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_CONV;
                end
            end
            ST_DONE: begin
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, digit folding and priority rotation after each response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
            r_id   <= 1'b0;
            r_err  <= 1'b0;
            r_acc  <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_opnd <= w_grant1 ? req1_bcd : req0_bcd;
                        r_id   <= w_grant1;
                        r_acc  <= '0;
                        r_err  <= 1'b0;
                        r_cnt  <= CW'(N - 1);
                    end
                end
                ST_CONV: begin
                    r_acc <= w_acc_nxt;
                    r_err <= r_err | nibble_invalid(w_digit);
                    if (r_cnt != CW'(0)) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    // Hand priority to the requester that was not just served.
                    if (rsp_ready) begin
                        r_prio <= ~r_id;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_bin   = r_acc;
    assign rsp_id    = r_id;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Testbench for bcd2bin_arbiter: transaction-level reference model compared
// every cycle, plus directed scenarios with hand-computed expected results.
module tb_bcd2bin_arbiter;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [W-1:0] req0_bcd;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_bcd;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_bin;
    logic         rsp_id;
    logic         rsp_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int           got_bin[$];
    int           got_id[$];
    int           got_err[$];
    int           rsp_cycs[$];
    int           acc_cycs[$];

    // Reference model state (transaction level)
    bit m_live = 1'b0;
    bit m_idle = 1'b1;
    bit m_rsp  = 1'b0;
    bit m_prio = 1'b0;
    bit m_id   = 1'b0;
    bit m_err  = 1'b0;
    int m_bin  = 0;
    int m_left = 0;

    bcd2bin_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_bcd   (req0_bcd),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_bcd   (req1_bcd),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_bin    (rsp_bin),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Decimal value of a packed BCD word: sum of digit * 10^position.
    function automatic int bcd_val(input logic [W-1:0] b);
        int v = 0;
        int p = 1;
        for (int i = 0; i < N; i++) begin
            v += int'(b[4*i +: 4]) * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic bit bcd_bad(input logic [W-1:0] b);
        bit e = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (b[4*i +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    // Reference model: one acceptance, N digit cycles, then hold until consumed.
    always @(posedge clk) begin
        bit g0, g1;
        logic [W-1:0] op;
        cyc++;
        if (rst) begin
            m_live = 1'b1; m_idle = 1'b1; m_rsp = 1'b0; m_prio = 1'b0;
            m_id = 1'b0; m_err = 1'b0; m_bin = 0; m_left = 0;
        end else if (m_live) begin
            if (m_idle) begin
                g0 = req0_valid && (!req1_valid || !m_prio);
                g1 = req1_valid && (!req0_valid || m_prio);
                if (g0 || g1) begin
                    op     = g1 ? req1_bcd : req0_bcd;
                    m_id   = g1;
                    m_bin  = bcd_val(op);
                    m_err  = bcd_bad(op);
                    m_left = N;
                    m_idle = 1'b0;
                end
            end else if (!m_rsp) begin
                m_left--;
                if (m_left == 0) m_rsp = 1'b1;
            end else if (rsp_ready) begin
                m_rsp  = 1'b0;
                m_idle = 1'b1;
                m_prio = !m_id;
            end
        end
    end

    // Compare DUT against the model every cycle; log handshakes for directed checks.
    always @(negedge clk) begin
        if (m_live) begin
            chk("req0_ready", req0_ready, m_idle && req0_valid && (!req1_valid || !m_prio));
            chk("req1_ready", req1_ready, m_idle && req1_valid && (!req0_valid || m_prio));
            chk("rsp_valid", rsp_valid, m_rsp);
            if (m_rsp) begin
                chk("rsp_bin", rsp_bin, m_bin);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_err", rsp_err, m_err);
            end
            if (!rst && rsp_valid && rsp_ready) begin
                got_bin.push_back(int'(rsp_bin));
                got_id.push_back(int'(rsp_id));
                got_err.push_back(int'(rsp_err));
                rsp_cycs.push_back(cyc);
            end
            if (!rst && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
                acc_cycs.push_back(cyc);
            end
        end
    end

    // Requester 0: presents queued operands, holds each until accepted.
    initial begin
        bit hs;
        req0_valid = 1'b0;
        req0_bcd   = '0;
        forever begin
            @(negedge clk);
            hs = req0_valid && req0_ready && !rst;
            @(posedge clk);
            #1;
            if (hs && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                req0_valid = 1'b1; req0_bcd = q0[0];
            end else begin
                req0_valid = 1'b0; req0_bcd = '0;
            end
        end
    end

    // Requester 1: same behaviour as requester 0.
    initial begin
        bit hs;
        req1_valid = 1'b0;
        req1_bcd   = '0;
        forever begin
            @(negedge clk);
            hs = req1_valid && req1_ready && !rst;
            @(posedge clk);
            #1;
            if (hs && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                req1_valid = 1'b1; req1_bcd = q1[0];
            end else begin
                req1_valid = 1'b0; req1_bcd = '0;
            end
        end
    end

    task automatic wait_rsp(input int n);
        int t = 0;
        while (got_bin.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("rsp_timeout", (got_bin.size() >= n), 1);
    endtask

    task automatic chk_rsp(input int idx, input int bin, input int id, input int err);
        chk($sformatf("rsp%0d_bin", idx), got_bin[idx], bin);
        chk($sformatf("rsp%0d_id", idx), got_id[idx], id);
        chk($sformatf("rsp%0d_err", idx), got_err[idx], err);
    endtask

    initial begin
        int t;
        int s;
        int bp_idx;
        rst       = 1'b1;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_bin", rsp_bin, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_err", rsp_err, 0);

        // Single request with latency check
        q0.push_back(16'h0259);
        wait_rsp(1);
        chk_rsp(0, 259, 0, 0);
        chk("latency", rsp_cycs[0] - acc_cycs[0], N + 1);

        // Contention right after reset
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        q0.push_back(16'h9999);
        q1.push_back(16'h1000);
        wait_rsp(3);
        chk_rsp(1, 9999, 0, 0);
        chk_rsp(2, 1000, 1, 0);

        // Fairness with both requesters continuously valid
        @(negedge clk);
        q0.push_back(16'h0001); q0.push_back(16'h0002); q0.push_back(16'h0003);
        q1.push_back(16'h0011); q1.push_back(16'h0012); q1.push_back(16'h0013);
        wait_rsp(9);
        chk_rsp(3, 1, 0, 0);
        chk_rsp(4, 11, 1, 0);
        chk_rsp(5, 2, 0, 0);
        chk_rsp(6, 12, 1, 0);
        chk_rsp(7, 3, 0, 0);
        chk_rsp(8, 13, 1, 0);

        // Backpressure
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        q0.push_back(16'h2599);
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reach", rsp_valid, 1);
        bp_idx = acc_cycs.size();
        q1.push_back(16'h0042);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_bin", rsp_bin, 2599);
            chk("bp_id", rsp_id, 0);
            chk("bp_rdy0", req0_ready, 0);
            chk("bp_rdy1", req1_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_rsp(11);
        chk_rsp(9, 2599, 0, 0);
        chk_rsp(10, 42, 1, 0);
        chk("bp_next_accept", acc_cycs[bp_idx] - rsp_cycs[9], 1);

        // Invalid digit, then err cleared for the next operand
        @(negedge clk);
        q1.push_back(16'h12A4);
        q1.push_back(16'h0000);
        wait_rsp(13);
        chk_rsp(11, 1304, 1, 1);
        chk_rsp(12, 0, 1, 0);

        // Reset during the second conversion cycle
        @(negedge clk);
        s = acc_cycs.size();
        q0.push_back(16'h0777);
        t = 0;
        while (acc_cycs.size() == s && t < 50) begin
            @(posedge clk);
            t++;
        end
        chk("mid_accept", (acc_cycs.size() > s), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_bin", rsp_bin, 0);
        chk("mid_rsp_id", rsp_id, 0);
        chk("mid_rsp_err", rsp_err, 0);
        chk("mid_rdy0", req0_ready, 0);
        repeat (10) @(posedge clk);
        chk("mid_no_rsp", got_bin.size(), 13);
        @(negedge clk);
        q0.push_back(16'h0001);
        q1.push_back(16'h0005);
        wait_rsp(15);
        chk_rsp(13, 1, 0, 0);
        chk_rsp(14, 5, 1, 0);

        // Pin the reference helpers themselves
        chk("model_val", bcd_val(16'h12A4), 1304);
        chk("model_bad", bcd_bad(16'h12A4), 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
